cache_mem_arbiter: RTL and testbench

//  Sits between the I-cache and D-cache fill FSMs and the single multicycle main memory.

---
 rtl/cache_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single main memory between the I-cache and D-cache line-fill FSMs.
// Optional build macro ARB_ROUND_ROBIN_EN: ties in IDLE go to the cache that was not granted last.
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int BEATS  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_data_valid,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_grant,
    output logic              d_data_valid,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    output logic              arb_busy
);

    localparam logic [CNT_W-1:0] LP_BEATS = CNT_W'(BEATS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_tie_pick;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_recv_cnt;
    logic [CNT_W-1:0] w_issue_nxt;
    logic [CNT_W-1:0] w_recv_nxt;
    logic             r_owner_i;
    logic             w_owner_i_nxt;
    logic             r_hold;
    logic             w_own_i;
    logic             w_own_d;
    logic             w_in_grant;
    logic             w_owner_miss;
    logic             w_beat;

    always_comb begin
        w_own_i      = (r_state == S_GRANT_I) | ((r_state == S_DRAIN) & r_owner_i);
        w_own_d      = (r_state == S_GRANT_D) | ((r_state == S_DRAIN) & ~r_owner_i);
        w_in_grant   = (r_state == S_GRANT_I) | (r_state == S_GRANT_D);
        w_owner_miss = (r_state == S_GRANT_I) ? i_miss : d_miss;

        i_grant      = w_own_i;
        d_grant      = w_own_d;
        mem_en       = w_in_grant & w_owner_miss & (r_issue_cnt < LP_BEATS);
        mem_addr     = '0;
        if (mem_en) begin
            mem_addr = (r_state == S_GRANT_I) ? i_addr : d_addr;
        end

        // Beats are steered to the owner even while draining; IDLE beats are dropped.
        i_data_valid = mem_data_valid & w_own_i;
        d_data_valid = mem_data_valid & w_own_d;
        w_beat       = mem_data_valid & (w_own_i | w_own_d) & (r_recv_cnt < r_issue_cnt);

        w_issue_nxt  = r_issue_cnt + CNT_W'(mem_en);
        w_recv_nxt   = r_recv_cnt + CNT_W'(w_beat);
        arb_busy     = (r_state != S_IDLE) | i_miss | d_miss;
    end

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        w_tie_pick = r_owner_i ? S_GRANT_D : S_GRANT_I;
`else
        w_tie_pick = S_GRANT_D;
`endif
        w_state_nxt   = r_state;
        w_owner_i_nxt = r_owner_i;
        case (r_state)
            S_IDLE: begin
                // r_hold keeps IDLE for one cycle so a just-finished owner's stale miss is not re-granted.
                if (!r_hold) begin
                    if (i_miss && d_miss) begin
                        w_state_nxt = w_tie_pick;
                    end else if (d_miss) begin
                        w_state_nxt = S_GRANT_D;
                    end else if (i_miss) begin
                        w_state_nxt = S_GRANT_I;
                    end
                end
                if (w_state_nxt == S_GRANT_I) begin
                    w_owner_i_nxt = 1'b1;
                end else if (w_state_nxt == S_GRANT_D) begin
                    w_owner_i_nxt = 1'b0;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if ((r_issue_cnt == LP_BEATS) && (w_recv_nxt == LP_BEATS)) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_owner_miss) begin
                    w_state_nxt = (w_recv_nxt == r_issue_cnt) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_recv_nxt == r_issue_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_owner_i   <= 1'b0;
            r_hold      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner_i <= w_owner_i_nxt;
            r_hold    <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
            if (w_state_nxt == S_IDLE) begin
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end else begin
                r_issue_cnt <= w_issue_nxt;
                r_recv_cnt  <= w_recv_nxt;
            end
        end
    end

`ifndef SYNTHESIS
    // Stray beats before the first grant after reset are residue of an aborted line, not errors.
    logic r_sim_granted;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sim_granted <= 1'b0;
        end else begin
            if (r_state != S_IDLE) begin
                r_sim_granted <= 1'b1;
            end
            if (mem_data_valid && (w_own_i || w_own_d) && (r_recv_cnt >= r_issue_cnt)) begin
                $error("cache_mem_arbiter: beat returned with no read outstanding");
            end
            if (mem_data_valid && (r_state == S_IDLE) && r_sim_granted) begin
                $error("cache_mem_arbiter: memory beat while IDLE");
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: fill-FSM models on both caches and a 4-cycle pipelined memory.
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int BEATS  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_miss = 1'b0;
    logic              d_miss = 1'b0;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic              i_grant;
    logic              d_grant;
    logic              i_data_valid;
    logic              d_data_valid;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic              arb_busy;
    logic [3:0]        mem_pipe = '0;

    int i_iss = 0;
    int i_rcv = 0;
    int d_iss = 0;
    int d_rcv = 0;
    int n_chk = 0;
    int n_err = 0;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .BEATS(BEATS), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_addr         (i_addr),
        .i_grant        (i_grant),
        .i_data_valid   (i_data_valid),
        .d_miss         (d_miss),
        .d_addr         (d_addr),
        .d_grant        (d_grant),
        .d_data_valid   (d_data_valid),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .arb_busy       (arb_busy)
    );

    always #5 clk = ~clk;

    assign mem_data_valid = mem_pipe[3];
    assign i_addr = 16'h1230 + 16'(2 * i_iss);
    assign d_addr = 16'h4000 + 16'(2 * d_iss);

    always @(posedge clk) begin
        mem_pipe <= {mem_pipe[2:0], mem_en};
        if (!i_miss) begin
            i_iss <= 0;
            i_rcv <= 0;
        end else begin
            if (i_grant && mem_en) i_iss <= i_iss + 1;
            if (i_data_valid) i_rcv <= i_rcv + 1;
        end
        if (!d_miss) begin
            d_iss <= 0;
            d_rcv <= 0;
        end else begin
            if (d_grant && mem_en) d_iss <= d_iss + 1;
            if (d_data_valid) d_rcv <= d_rcv + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit inr(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic check_cyc(input string t, input int k, input bit ig, input bit dg, input bit me,
                             input logic [15:0] ad, input bit idv, input bit ddv, input bit busy);
        chk($sformatf("%s i_grant@%0d", t, k), 32'(i_grant), 32'(ig));
        chk($sformatf("%s d_grant@%0d", t, k), 32'(d_grant), 32'(dg));
        chk($sformatf("%s mem_en@%0d", t, k), 32'(mem_en), 32'(me));
        chk($sformatf("%s mem_addr@%0d", t, k), 32'(mem_addr), 32'(ad));
        chk($sformatf("%s i_dv@%0d", t, k), 32'(i_data_valid), 32'(idv));
        chk($sformatf("%s d_dv@%0d", t, k), 32'(d_data_valid), 32'(ddv));
        chk($sformatf("%s busy@%0d", t, k), 32'(arb_busy), 32'(busy));
    endtask

    // Advance one clock; a fill FSM drops its miss once its whole line has come back.
    task automatic tick();
        @(posedge clk);
        #1;
        if (i_miss && i_rcv == BEATS) i_miss = 1'b0;
        if (d_miss && d_rcv == BEATS) d_miss = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        i_miss = 1'b0;
        d_miss = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_cyc("reset", 0, 0, 0, 0, 16'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // First requester owns cycles 1..12; a second waiting requester owns 15..26.
    task automatic run_pair(input string t, input bit first_i, input bit both, input int s_rise);
        logic [15:0] fb;
        logic [15:0] sb;
        fb = first_i ? 16'h1230 : 16'h4000;
        sb = first_i ? 16'h4000 : 16'h1230;
        if (first_i) i_miss = 1'b1; else d_miss = 1'b1;
        if (both && s_rise == 0) begin
            if (first_i) d_miss = 1'b1; else i_miss = 1'b1;
        end
        for (int k = 0; k <= 28; k++) begin
            bit g1, g2, m1, m2, v1, v2, busy;
            logic [15:0] ad;
            g1 = inr(k, 1, 12);
            g2 = both && inr(k, 15, 26);
            m1 = inr(k, 1, 8);
            m2 = both && inr(k, 15, 22);
            v1 = inr(k, 5, 12);
            v2 = both && inr(k, 19, 26);
            ad = m1 ? fb + 16'(2 * (k - 1)) : (m2 ? sb + 16'(2 * (k - 15)) : 16'h0);
            busy = (k <= 12) || (both && k >= s_rise && k <= 26);
            @(negedge clk);
            check_cyc(t, k, first_i ? g1 : g2, first_i ? g2 : g1, m1 | m2, ad,
                      first_i ? v1 : v2, first_i ? v2 : v1, busy);
            tick();
            if (both && s_rise > 0 && k + 1 == s_rise) begin
                if (first_i) d_miss = 1'b1; else i_miss = 1'b1;
            end
        end
    endtask

    task automatic test_abort();
        d_miss = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check_cyc("t4", k, 0, inr(k, 1, 7), inr(k, 1, 3),
                      inr(k, 1, 3) ? 16'h4000 + 16'(2 * (k - 1)) : 16'h0, 0, inr(k, 5, 7), k <= 7);
            if (k == 8) begin
                chk("t4 issue_cnt", 32'(dut.r_issue_cnt), 32'd0);
                chk("t4 recv_cnt", 32'(dut.r_recv_cnt), 32'd0);
            end
            tick();
            if (k + 1 == 4) d_miss = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        i_miss = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check_cyc("t5pre", k, inr(k, 1, 8), 0, inr(k, 1, 8),
                      inr(k, 1, 8) ? 16'h1230 + 16'(2 * (k - 1)) : 16'h0, inr(k, 5, 8), 0, 1);
            tick();
        end
        rst_n  = 1'b0;
        i_miss = 1'b0;
        @(negedge clk);
        check_cyc("t5rst", 9, 0, 0, 0, 16'h0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 10; k <= 12; k++) begin
            @(negedge clk);
            check_cyc("t5stale", k, 0, 0, 0, 16'h0, 0, 0, 0);
            tick();
        end
        d_miss = 1'b1;
        for (int k = 13; k <= 28; k++) begin
            int o;
            o = k - 13;
            @(negedge clk);
            check_cyc("t5d", k, 0, inr(o, 1, 12), inr(o, 1, 8),
                      inr(o, 1, 8) ? 16'h4000 + 16'(2 * (o - 1)) : 16'h0, 0, inr(o, 5, 12), o <= 12);
            tick();
        end
    endtask

    initial begin
        do_reset();
        run_pair("t1", 1'b1, 1'b0, 0);
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        run_pair("t3a", 1'b1, 1'b1, 0);
        run_pair("t3b", 1'b1, 1'b0, 0);
        run_pair("t3c", 1'b0, 1'b1, 0);
`else
        run_pair("t2a", 1'b0, 1'b1, 0);
        run_pair("t2b", 1'b0, 1'b1, 0);
`endif
        do_reset();
        test_abort();
        do_reset();
        test_reset_mid();
        do_reset();
        run_pair("t6", 1'b1, 1'b1, 5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
